// File: rtl/enha_pkg.sv
// enha_pkg: shared constants and types for the enhancement-rate generator.
//   Rate codes    : RATE_X1 (x1), RATE_X3_4, RATE_X1_2, RATE_X1_4 (x1/4)
//   Thresholds    : THR_192 / THR_128 / THR_64, the clip level of codes 01/10/11
//   state_t       : IDLE / ACCUM / DECIDE frame-statistics state machine
package enha_pkg;

    localparam logic [1:0] RATE_X1   = 2'b00;
    localparam logic [1:0] RATE_X3_4 = 2'b01;
    localparam logic [1:0] RATE_X1_2 = 2'b10;
    localparam logic [1:0] RATE_X1_4 = 2'b11;

    localparam int THR_192 = 192;
    localparam int THR_128 = 128;
    localparam int THR_64  = 64;

    localparam int NUM_THR = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2
    } state_t;

endpackage

// File: rtl/enha_rate_gen_thr_counter.sv
// thr_counter: one saturating compare-and-count unit.
//   Counts cycles where iDE is high and pixel >= THR; saturates at all-ones.
//   clear restarts the count, but a hit in the same cycle still counts (0 + inc),
//   so the pixel coincident with a frame boundary belongs to the new frame.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart count this cycle
//   iDE        : pixel valid
//   pixel      : 8-bit pixel value
//   cnt        : current count
module thr_counter
    import enha_pkg::*;
#(
    parameter int THR   = THR_64,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             iDE,
    input  logic [7:0]       pixel,
    output logic [CNT_W-1:0] cnt
);

    logic hit;

    // 9-bit compare so a threshold of 256 would be expressible
    assign hit = iDE && ({1'b0, pixel} >= 9'(THR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= {{(CNT_W-1){1'b0}}, hit};
        else if (hit && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/enha_rate_gen.sv
// enha_rate_gen: per-block enhancement-rate generator for backlight dimming.
//   Counts pixels at or above 192/128/64 over a frame; on each iVS it snapshots
//   the counts and, one cycle later, registers the strongest rate whose clip
//   count is <= CLIP_CNT. Result visible two cycles after iVS.
//   Optional macro ENHA_RATE_SLEW_EN: rate moves one code step per decision.
// Ports:
//   iODCK      : pixel clock
//   iRST       : asynchronous active-low reset
//   iVS        : frame-boundary strobe
//   iDE        : pixel valid
//   iBpixel    : block pixel value
//   oEnhaRate  : rate code (00 x1, 01 x3/4, 10 x1/2, 11 x1/4)
//   oRateVld   : one-cycle pulse per decision
//   oFirstDone : high once the first frame has been evaluated
module enha_rate_gen
    import enha_pkg::*;
#(
    parameter int CNT_W    = 12,
    parameter int CLIP_CNT = 0
) (
    input  logic       iODCK,
    input  logic       iRST,
    input  logic       iVS,
    input  logic       iDE,
    input  logic [7:0] iBpixel,
    output logic [1:0] oEnhaRate,
    output logic       oRateVld,
    output logic       oFirstDone
);

    localparam logic [CNT_W-1:0] CLIP = CNT_W'(CLIP_CNT);

    state_t state, state_nxt;

    // index 0/1/2 = threshold of code 01/10/11
    logic [NUM_THR-1:0][CNT_W-1:0] cnt;
    logic [NUM_THR-1:0][CNT_W-1:0] snap;
    logic       cnt_clear, cnt_de, snap_ld;
    logic [1:0] target, rate_nxt;

    // IDLE holds the counters at zero; the first iVS starts a frame and
    // its coincident pixel already counts.
    assign cnt_clear = iVS || (state == IDLE);
    assign cnt_de    = iDE && ((state != IDLE) || iVS);
    assign snap_ld   = iVS && (state != IDLE);

    for (genvar g = 0; g < NUM_THR; g++) begin : g_thr
        localparam int T = (g == 0) ? THR_192 : (g == 1) ? THR_128 : THR_64;
        thr_counter #(.THR(T), .CNT_W(CNT_W)) u_cnt (
            .clk   (iODCK),
            .rst_n (iRST),
            .clear (cnt_clear),
            .iDE   (cnt_de),
            .pixel (iBpixel),
            .cnt   (cnt[g])
        );
    end

    always_ff @(posedge iODCK or negedge iRST) begin
        if (!iRST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (iVS) state_nxt = ACCUM;
            ACCUM:   if (iVS) state_nxt = DECIDE;
            DECIDE:  state_nxt = iVS ? DECIDE : ACCUM;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iODCK or negedge iRST) begin
        if (!iRST)
            snap <= '0;
        else if (snap_ld)
            snap <= cnt;
    end

    // Largest qualifying code wins; counts are monotonic so later checks
    // only ever upgrade the choice.
    always_comb begin
        target = RATE_X1;
        if (snap[0] <= CLIP) target = RATE_X3_4;
        if (snap[1] <= CLIP) target = RATE_X1_2;
        if (snap[2] <= CLIP) target = RATE_X1_4;
    end

    always_comb begin
        rate_nxt = target;
`ifdef ENHA_RATE_SLEW_EN
        if (target > oEnhaRate)
            rate_nxt = oEnhaRate + 2'd1;
        else if (target < oEnhaRate)
            rate_nxt = oEnhaRate - 2'd1;
        else
            rate_nxt = oEnhaRate;
`endif
    end

    // Decision registered at the end of DECIDE; an iVS in DECIDE still
    // uses the old snapshot here because snap updates on the same edge.
    always_ff @(posedge iODCK or negedge iRST) begin
        if (!iRST) begin
            oEnhaRate  <= RATE_X1;
            oRateVld   <= 1'b0;
            oFirstDone <= 1'b0;
        end else begin
            oRateVld <= (state == DECIDE);
            if (state == DECIDE) begin
                oEnhaRate  <= rate_nxt;
                oFirstDone <= 1'b1;
            end
        end
    end

endmodule
